lcd_bus_arbiter: RTL and testbench

Shares one HD44780-style character LCD bus between two independent write clients (e.g. a text scroller and a status writer).
- Runs the power-up init sequence itself.
- Round-robin arbitrates client requests; each client presents one rs/data byte per valid/ready handshake.
- Generates the e strobe and enforces per-command settle time, with a long wait after clear/home.
- Sits between the text-generation logic and the LCD pins; it is the only driver of lcd_e/lcd_rs/lcd_rw/lcd_data.

---
 rtl/lcd_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// HD44780-style LCD bus owner: runs the power-up init sequence, then round-robin
// shares the bus between two write clients with e-strobe generation and settle hold-off.
module lcd_bus_arbiter #(
  parameter int CLK_DIV    = 5,
  parameter int INIT_WAIT  = 70,
  parameter int SHORT_WAIT = 2,
  parameter int LONG_WAIT  = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic       grant_id,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int MAX_IL   = (INIT_WAIT > LONG_WAIT) ? INIT_WAIT : LONG_WAIT;
  localparam int MAX_WAIT = (MAX_IL > SHORT_WAIT) ? MAX_IL : SHORT_WAIT;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_INIT_DLY,
    S_INIT_LD,
    S_IDLE,
    S_SETUP,
    S_E_HI,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic              in_init_q, in_init_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              e_q, e_d;

  logic              tick;
  logic              idle;
  logic              pick0, pick1;
  logic              long_cmd;
  logic [WAIT_W-1:0] hold_last;
  logic [7:0]        init_byte;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign idle = (state_q == S_IDLE);

  // When both clients are valid, the one that did not win last time goes next.
  assign pick1 = req1_valid & (~req0_valid | ~last_grant_q);
  assign pick0 = req0_valid & (~req1_valid | last_grant_q);

  assign req0_ready = idle & pick0;
  assign req1_ready = idle & pick1;

  // Clear (0x01) and home (0x02/0x03) need the long settle time.
  assign long_cmd  = ~rs_q & (data_q[7:2] == 6'd0);
  assign hold_last = long_cmd ? WAIT_W'(LONG_WAIT - 1) : WAIT_W'(SHORT_WAIT - 1);

  always_comb begin
    case (init_idx_q)
      2'd0:    init_byte = 8'h3C;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT_DLY;
      wait_q       <= '0;
      init_idx_q   <= 2'd0;
      in_init_q    <= 1'b1;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      e_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      init_idx_q   <= init_idx_d;
      in_init_q    <= in_init_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      e_q          <= e_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    init_idx_d   = init_idx_q;
    in_init_d    = in_init_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rs_d         = rs_q;
    data_d       = data_q;

    case (state_q)
      S_INIT_DLY: begin
        if (tick) begin
          if (wait_q == WAIT_W'(INIT_WAIT - 1)) begin
            wait_d  = '0;
            state_d = S_INIT_LD;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_INIT_LD: begin
        if (tick) begin
          rs_d       = 1'b0;
          data_d     = init_byte;
          init_idx_d = init_idx_q + 2'd1;
          state_d    = S_SETUP;
        end
      end
      S_IDLE: begin
        if (pick0) begin
          rs_d         = req0_rs;
          data_d       = req0_data;
          grant_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = S_SETUP;
        end else if (pick1) begin
          rs_d         = req1_rs;
          data_d       = req1_data;
          grant_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_E_HI;
      end
      S_E_HI: begin
        if (tick) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (tick) begin
          if (wait_q == hold_last) begin
            wait_d = '0;
            // The init index wraps to 0 once the last init byte has been loaded.
            if (in_init_q && (init_idx_q != 2'd0)) begin
              state_d = S_INIT_LD;
            end else begin
              in_init_d = 1'b0;
              state_d   = S_IDLE;
            end
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      default: state_d = S_INIT_DLY;
    endcase

    e_d = (state_d == S_E_HI);
  end

  assign busy     = ~idle;
  assign grant_id = grant_q;
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: accepts and init bytes queue expected LCD
// writes; a negedge monitor checks each e pulse, its width, hold-off and arbitration.
module tb_lcd_bus_arbiter;

  localparam int CLK_DIV    = 2;
  localparam int INIT_WAIT  = 3;
  localparam int SHORT_WAIT = 2;
  localparam int LONG_WAIT  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic       busy, grant_id, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_bus_arbiter #(
    .CLK_DIV   (CLK_DIV),
    .INIT_WAIT (INIT_WAIT),
    .SHORT_WAIT(SHORT_WAIT),
    .LONG_WAIT (LONG_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_rs   (req0_rs),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_rs   (req1_rs),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic [7:0]  data;
    logic        gid;
    int unsigned w;
    bit          init_next;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mlast    = 1'b1;
  bit   acc0, acc1;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int unsigned wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d < 8'h04) ? LONG_WAIT : SHORT_WAIT;
  endfunction

  task automatic push_init();
    logic [7:0] seq [4];
    exp_t e;
    seq[0] = 8'h3C; seq[1] = 8'h0C; seq[2] = 8'h06; seq[3] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      e.rs = 1'b0; e.data = seq[k]; e.gid = 1'b0;
      e.w = wait_of(1'b0, seq[k]); e.init_next = (k != 3);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: arbitration model, scoreboard pops on e rising, timing of pulse and hold-off.
  exp_t cur;
  bit   in_pulse = 1'b0, holding = 1'b0;
  logic e_prev = 1'b0;
  int   rise_cyc, fall_cyc;

  always @(negedge clk) begin
    bit   exp_r0, exp_r1;
    exp_t e;
    cyc++;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!reset) begin
      in_pulse = 1'b0;
      holding  = 1'b0;
      e_prev   = 1'b0;
    end else begin
      exp_r0 = !busy && req0_valid && (!req1_valid || mlast);
      exp_r1 = !busy && req1_valid && (!req0_valid || !mlast);
      chk("ready0", req0_ready, exp_r0);
      chk("ready1", req1_ready, exp_r1);
      chk("rw", lcd_rw, 0);
      if (req0_valid && req0_ready) begin
        e.rs = req0_rs; e.data = req0_data; e.gid = 1'b0;
        e.w = wait_of(req0_rs, req0_data); e.init_next = 1'b0;
        exp_q.push_back(e); mlast = 1'b0; acc0 = 1'b1;
      end else if (req1_valid && req1_ready) begin
        e.rs = req1_rs; e.data = req1_data; e.gid = 1'b1;
        e.w = wait_of(req1_rs, req1_data); e.init_next = 1'b0;
        exp_q.push_back(e); mlast = 1'b1; acc1 = 1'b1;
      end
      if (lcd_e && !e_prev) begin
        if (holding) begin
          chk("gap_init_next", cur.init_next, 1);
          chk("init_gap", cyc - fall_cyc, (cur.w + 2) * CLK_DIV);
          holding = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_e actual=rs%0d/%02h required=none (cycle %0d)", lcd_rs, lcd_data, cyc);
          in_pulse = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          chk("xfer_rs", lcd_rs, cur.rs);
          chk("xfer_data", lcd_data, cur.data);
          chk("xfer_gid", grant_id, cur.gid);
          $display("xfer cycle=%0d rs=%0d data=%02h gid=%0d", cyc, lcd_rs, lcd_data, grant_id);
          in_pulse = 1'b1;
          rise_cyc = cyc;
        end
      end
      if (!lcd_e && e_prev && in_pulse) begin
        chk("e_width", cyc - rise_cyc, CLK_DIV);
        in_pulse = 1'b0;
        holding  = 1'b1;
        fall_cyc = cyc;
      end
      if (in_pulse || (holding && !cur.init_next)) begin
        chk("bus_stable_rs", lcd_rs, cur.rs);
        chk("bus_stable_data", lcd_data, cur.data);
      end
      if (holding && !busy) begin
        chk("hold_kind", cur.init_next, 0);
        chk("hold_time", cyc - fall_cyc, cur.w * CLK_DIV);
        holding = 1'b0;
      end
      e_prev = lcd_e;
    end
  end

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic send(input bit c, input logic rs, input logic [7:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (c) begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
    else   begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
    for (int n = 0; n < 500 && !got; n++) begin
      @(posedge clk); #1;
      got = c ? acc1 : acc0;
    end
    chk("send_accept", got, 1);
    if (c) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(7) == 0) return 8'($urandom_range(3));
    return 8'($urandom_range(255));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nacc;
    bit  nxt, seen;
    reset = 1'b0;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;

    // Reset values, then the autonomous init sequence.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_grant", grant_id, 0);
    mlast = 1'b1;
    exp_q.delete();
    push_init();
    reset = 1'b1;
    wait_idle(2000, "init_done");
    chk("init_drained", exp_q.size(), 0);

    // Single data write from client 0.
    send(1'b0, 1'b1, 8'h41);
    wait_idle(500, "single_idle");
    chk("single_grant", grant_id, 0);

    // Home command forces long spacing; set-address command short spacing.
    send(1'b1, 1'b0, 8'h02);
    send(1'b1, 1'b1, 8'h58);
    wait_idle(500, "home_idle");
    chk("home_grant", grant_id, 1);
    send(1'b1, 1'b0, 8'h80);
    send(1'b1, 1'b1, 8'h58);
    wait_idle(500, "addr_idle");

    // Both clients valid continuously: strict alternation starting with client 0.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h61;
    nacc = 0;
    nxt  = 1'b0;
    for (int n = 0; n < 1000 && nacc < 8; n++) begin
      @(posedge clk); #1;
      if (acc0) begin chk("alt_order", 0, nxt); nxt = ~nxt; nacc++; req0_data = req0_data + 8'd1; end
      if (acc1) begin chk("alt_order", 1, nxt); nxt = ~nxt; nacc++; req1_data = req1_data + 8'd1; end
    end
    chk("alt_count", nacc, 8);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(500, "alt_idle");

    // Valid raised and withdrawn while busy must not transfer.
    send(1'b0, 1'b1, 8'h45);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_idle(500, "drop_idle");
    chk("drop_data", lcd_data, 8'h45);
    chk("drop_drained", exp_q.size(), 0);

    // Randomized traffic from both clients.
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); #1;
      if (req0_valid && acc0) req0_valid = 1'b0;
      else if (req0_valid && $urandom_range(31) == 0) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(3) == 0) begin
        req0_valid = 1'b1; req0_rs = 1'($urandom_range(1)); req0_data = rand_byte();
      end
      if (req1_valid && acc1) req1_valid = 1'b0;
      else if (req1_valid && $urandom_range(31) == 0) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(3) == 0) begin
        req1_valid = 1'b1; req1_rs = 1'($urandom_range(1)); req1_data = rand_byte();
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(500, "rand_idle");
    chk("rand_drained", exp_q.size(), 0);

    // Reset while e is high: outputs drop at once and init restarts.
    send(1'b0, 1'b1, 8'h52);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = lcd_e;
    end
    chk("e_hi_seen", seen, 1);
    #2;
    reset = 1'b0;
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
    #1;
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_rs", lcd_rs, 0);
    chk("mid_rst_data", lcd_data, 0);
    chk("mid_rst_grant", grant_id, 0);
    mlast = 1'b1;
    exp_q.delete();
    push_init();
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_ready1", req1_ready, 0);
    end
    req1_valid = 1'b0;
    reset = 1'b1;
    wait_idle(2000, "reinit_done");
    chk("reinit_drained", exp_q.size(), 0);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
